// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end: base opcodes, the canonical NOP
// and the encoding of the fetch state machine.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: loads a word-aligned redirect target, steps by 4, or holds.
// Load takes priority over increment; the increment wraps modulo 2^XLEN.
module fetch_pc_reg #(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            load,
    input  logic [XLEN-1:0] load_addr,
    input  logic            incr,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_reg;

    // PC update: redirect target (low two bits cleared), next word, or hold
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= {load_addr[XLEN-1:2], 2'b00};
        end else if (incr) begin
            pc_reg <= pc_reg + XLEN'(4);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one instruction-memory request at a time, captures the
// returned word into the IF/ID register, and handles stall and redirect.
// Imem_req is registered; after reset the FSM sits in REQ with the strobe low
// and raises it on the first free cycle.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSN = NOP
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            Stall,
    input  logic            Branch_taken,
    input  logic [XLEN-1:0] Branch_target,
    output logic            Imem_req,
    output logic [XLEN-1:0] Imem_addr,
    input  logic [31:0]     Imem_rdata,
    input  logic            Imem_valid,
    output logic [31:0]     Instruction,
    output logic [6:0]      Opcode,
    output logic [XLEN-1:0] Pc_out,
    output logic            Valid_out
);

    fetch_state_t    state_reg;
    logic            req_reg;
    logic [31:0]     insn_reg;
    logic [XLEN-1:0] pc_out_reg;
    logic            valid_reg;
    logic [XLEN-1:0] pc;
    logic            accept;

    // A response is consumed in WAIT unless a redirect wins, or a stall is
    // active while IF/ID already holds a live word.
    assign accept = !Branch_taken && (state_reg == ST_WAIT) && Imem_valid
                    && (!Stall || !valid_reg);

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .load      (Branch_taken),
        .load_addr (Branch_target),
        .incr      (accept),
        .pc        (pc)
    );

    // Fetch FSM with the IF/ID register and the registered request strobe
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= ST_REQ;
            req_reg    <= 1'b0;
            insn_reg   <= NOP_INSN;
            pc_out_reg <= RESET_PC;
            valid_reg  <= 1'b0;
        end else if (Branch_taken) begin
            insn_reg  <= NOP_INSN;
            valid_reg <= 1'b0;
            if ((state_reg == ST_WAIT) && !Imem_valid) begin
                // the old request is still in flight; swallow its response
                state_reg <= ST_DROP;
                req_reg   <= 1'b0;
            end else begin
                state_reg <= ST_REQ;
                req_reg   <= 1'b1;
            end
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (req_reg) begin
                        state_reg <= ST_WAIT;
                        req_reg   <= 1'b0;
                    end else if (!Stall) begin
                        req_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        insn_reg   <= Imem_rdata;
                        pc_out_reg <= pc;
                        valid_reg  <= 1'b1;
                        if (Stall) begin
                            state_reg <= ST_HOLD;
                        end else begin
                            state_reg <= ST_REQ;
                            req_reg   <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (Imem_valid) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_REQ;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign Imem_req    = req_reg;
    assign Imem_addr   = pc;
    assign Instruction = insn_reg;
    assign Opcode      = insn_reg[6:0];
    assign Pc_out      = pc_out_reg;
    assign Valid_out   = valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small behavioural memory that
// answers each request after 1 + mem_delay cycles and holds its response
// until the next request.
module tb_instruction_fetch;

    logic        Clock;
    logic        Reset_n;
    logic        Stall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_rdata;
    logic        Imem_valid;
    logic [31:0] Instruction;
    logic [6:0]  Opcode;
    logic [31:0] Pc_out;
    logic        Valid_out;

    // second instance for the PC wrap case
    logic        Imem_req2;
    logic [31:0] Imem_addr2;
    logic [31:0] Imem_rdata2;
    logic        Imem_valid2;
    logic [31:0] Instruction2;
    logic [6:0]  Opcode2;
    logic [31:0] Pc_out2;
    logic        Valid_out2;
    logic        Stall2;
    logic        Branch_taken2;
    logic [31:0] Branch_target2;

    int errors = 0;
    int checks = 0;
    int mem_delay = 0;
    logic [31:0] log2 [2];
    int n2 = 0;

    instruction_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Stall         (Stall),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .Imem_req      (Imem_req),
        .Imem_addr     (Imem_addr),
        .Imem_rdata    (Imem_rdata),
        .Imem_valid    (Imem_valid),
        .Instruction   (Instruction),
        .Opcode        (Opcode),
        .Pc_out        (Pc_out),
        .Valid_out     (Valid_out)
    );

    instruction_fetch #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INSN (32'h0000_0013)
    ) dut_wrap (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Stall         (Stall2),
        .Branch_taken  (Branch_taken2),
        .Branch_target (Branch_target2),
        .Imem_req      (Imem_req2),
        .Imem_addr     (Imem_addr2),
        .Imem_rdata    (Imem_rdata2),
        .Imem_valid    (Imem_valid2),
        .Instruction   (Instruction2),
        .Opcode        (Opcode2),
        .Pc_out        (Pc_out2),
        .Valid_out     (Valid_out2)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0000_0033;
        else if (a == 32'h4)
            return 32'h0000_2003;
        else
            return {a[24:0], 7'b0110111};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // memory for the main instance
    initial begin : mem_main
        logic [31:0] lat;
        int cnt;
        lat = '0;
        cnt = 0;
        Imem_valid = 1'b0;
        Imem_rdata = '0;
        forever begin
            @(negedge Clock);
            if (Imem_req) begin
                Imem_valid = 1'b0;
                lat = Imem_addr;
                cnt = 1 + mem_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    Imem_valid = 1'b1;
                    Imem_rdata = mem_word(lat);
                end
            end
        end
    end

    // zero-wait memory for the wrap instance, logging the first two addresses
    initial begin : mem_wrap
        logic [31:0] lat;
        int cnt;
        lat = '0;
        cnt = 0;
        Imem_valid2 = 1'b0;
        Imem_rdata2 = '0;
        forever begin
            @(negedge Clock);
            if (Imem_req2) begin
                Imem_valid2 = 1'b0;
                lat = Imem_addr2;
                cnt = 1;
                if (n2 < 2) log2[n2] = Imem_addr2;
                n2++;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    Imem_valid2 = 1'b1;
                    Imem_rdata2 = mem_word(lat);
                end
            end
        end
    end

    initial begin
        Reset_n        = 1'b0;
        Stall          = 1'b0;
        Branch_taken   = 1'b0;
        Branch_target  = '0;
        Stall2         = 1'b0;
        Branch_taken2  = 1'b0;
        Branch_target2 = '0;
        log2[0] = 32'hDEAD_BEEF;
        log2[1] = 32'hDEAD_BEEF;

        repeat (2) tick();
        check_val("rst_req",   32'(Imem_req),  32'h0);
        check_val("rst_insn",  Instruction,    32'h0000_0013);
        check_val("rst_pcout", Pc_out,         32'h0);
        check_val("rst_valid", 32'(Valid_out), 32'h0);
        check_val("rst_addr",  Imem_addr,      32'h0);
        Reset_n = 1'b1;

        // 1: two back-to-back fetches with zero-wait memory
        tick();
        check_val("t1_req1",  32'(Imem_req), 32'h1);
        check_val("t1_addr1", Imem_addr,     32'h0);
        tick();
        check_val("t1_req_wait", 32'(Imem_req), 32'h0);
        tick();
        check_val("t1_op1",    32'(Opcode),    32'h33);
        check_val("t1_pc1",    Pc_out,         32'h0);
        check_val("t1_valid1", 32'(Valid_out), 32'h1);
        check_val("t1_req3",   32'(Imem_req),  32'h1);
        check_val("t1_addr3",  Imem_addr,      32'h4);
        tick();
        tick();
        check_val("t1_op2",   32'(Opcode),   32'h03);
        check_val("t1_pc2",   Pc_out,        32'h4);
        check_val("t1_addr5", Imem_addr,     32'h8);

        // 2: stall for 3 cycles with IF/ID live; response waits unconsumed
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("t2_req_%0d", i),  32'(Imem_req), 32'h0);
            check_val($sformatf("t2_insn_%0d", i), Instruction,   32'h0000_2003);
            check_val($sformatf("t2_pc_%0d", i),   Pc_out,        32'h4);
        end
        Stall = 1'b0;
        mem_delay = 1;
        tick();
        check_val("t2_insn_after", Instruction,   mem_word(32'h8));
        check_val("t2_pc_after",   Pc_out,        32'h8);
        check_val("t2_req_after",  32'(Imem_req), 32'h1);
        check_val("t2_addr_after", Imem_addr,     32'hC);

        // 3: redirect in WAIT before the (slow) response arrives
        tick();
        Branch_taken  = 1'b1;
        Branch_target = 32'h0000_0103;
        tick();
        Branch_taken = 1'b0;
        mem_delay = 0;
        check_val("t3_valid", 32'(Valid_out), 32'h0);
        check_val("t3_insn",  Instruction,    32'h0000_0013);
        check_val("t3_req",   32'(Imem_req),  32'h0);
        tick();
        check_val("t3_req2",   32'(Imem_req),  32'h1);
        check_val("t3_addr2",  Imem_addr,      32'h100);
        check_val("t3_valid2", 32'(Valid_out), 32'h0);
        tick();
        tick();
        check_val("t3_insn_cap", Instruction, mem_word(32'h100));
        check_val("t3_pc_cap",   Pc_out,      32'h100);
        check_val("t3_addr_nxt", Imem_addr,   32'h104);

        // 4: redirect coinciding with the response
        tick();
        Branch_taken  = 1'b1;
        Branch_target = 32'h0000_0200;
        tick();
        Branch_taken = 1'b0;
        Stall = 1'b1;
        check_val("t4_insn",  Instruction,    32'h0000_0013);
        check_val("t4_valid", 32'(Valid_out), 32'h0);
        check_val("t4_req",   32'(Imem_req),  32'h1);
        check_val("t4_addr",  Imem_addr,      32'h200);
        // first capture after the flush with Stall high parks in HOLD
        tick();
        tick();
        check_val("hold_insn",  Instruction,    mem_word(32'h200));
        check_val("hold_pc",    Pc_out,         32'h200);
        check_val("hold_valid", 32'(Valid_out), 32'h1);
        check_val("hold_req",   32'(Imem_req),  32'h0);
        tick();
        check_val("hold_req2", 32'(Imem_req), 32'h0);
        check_val("hold_pc2",  Pc_out,        32'h200);
        Stall = 1'b0;
        tick();
        check_val("hold_exit_req",  32'(Imem_req), 32'h1);
        check_val("hold_exit_addr", Imem_addr,     32'h204);

        // 6: reset pulse in WAIT while a response is about to land
        tick();
        Reset_n = 1'b0;
        #1;
        check_val("t6_req",   32'(Imem_req),  32'h0);
        check_val("t6_insn",  Instruction,    32'h0000_0013);
        check_val("t6_valid", 32'(Valid_out), 32'h0);
        check_val("t6_pcout", Pc_out,         32'h0);
        check_val("t6_addr",  Imem_addr,      32'h0);
        Reset_n = 1'b1;
        tick();
        check_val("t6_req2",   32'(Imem_req),  32'h1);
        check_val("t6_addr2",  Imem_addr,      32'h0);
        check_val("t6_valid2", 32'(Valid_out), 32'h0);
        tick();
        tick();
        check_val("t6_insn_cap", Instruction,    32'h0000_0033);
        check_val("t6_pc_cap",   Pc_out,         32'h0);
        check_val("t6_valid3",   32'(Valid_out), 32'h1);

        // 5: PC wrap from 0xFFFF_FFFC
        check_val("t5_addr0", log2[0], 32'hFFFF_FFFC);
        check_val("t5_addr1", log2[1], 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
